// File: rtl/bus_bridge_pkg.sv
// Shared request/response payload types and frame constants for the UART bus bridge.
package bus_bridge_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  write_data;
        logic        is_write;
    } bus_bridge_req_t;

    typedef struct packed {
        logic [7:0] read_data;
        logic       is_write;
    } bus_bridge_resp_t;

    localparam int unsigned REQ_FRAME_BYTES  = 4;
    localparam int unsigned RESP_FRAME_BYTES = 2;

    // Second response byte carries only the write flag in its LSB.
    function automatic logic [7:0] resp_flags_byte(input bus_bridge_resp_t resp);
        return {7'b0000000, resp.is_write};
    endfunction

endpackage

// File: rtl/ot_uart.sv
// 8N1 UART: receive byte latched with a sticky ready flag, transmit with a busy flag.
module ot_uart #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 wr_en,
    input  logic                 clear,
    input  logic                 ready_clr,
    input  logic                 Rx,
    output logic                 Tx,
    output logic                 Tx_busy,
    output logic                 ready,
    output logic [DATA_BITS-1:0] data_out
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0] BIT_STOP = BIT_W'(DATA_BITS + 1);

    logic [1:0]           rx_sync_r;
    logic                 rx_busy_r;
    logic [CNT_W-1:0]     rx_cnt_r;
    logic [BIT_W-1:0]     rx_bit_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_stop_ok_s;
    logic                 ready_r;
    logic [DATA_BITS-1:0] data_out_r;
    logic                 tx_r;
    logic                 tx_busy_r;
    logic [CNT_W-1:0]     tx_cnt_r;
    logic [BIT_W-1:0]     tx_bit_r;
    logic [DATA_BITS:0]   tx_shift_r;

    assign rx_stop_ok_s = rx_busy_r && (rx_cnt_r == CNT_HALF) && (rx_bit_r == BIT_STOP) && rx_sync_r[1];
    assign ready        = ready_r;
    assign data_out     = data_out_r;
    assign Tx           = tx_r;
    assign Tx_busy      = tx_busy_r;

    // Receive engine: two-flop synchroniser, mid-bit sampling, false-start rejection.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_r  <= 2'b11;
            rx_busy_r  <= 1'b0;
            rx_cnt_r   <= '0;
            rx_bit_r   <= '0;
            rx_shift_r <= '0;
        end else begin
            rx_sync_r <= {rx_sync_r[0], Rx};
            if (!rx_busy_r) begin
                if (!rx_sync_r[1]) begin
                    rx_busy_r <= 1'b1;
                    rx_cnt_r  <= '0;
                    rx_bit_r  <= '0;
                end
            end else begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_r <= '0;
                    rx_bit_r <= rx_bit_r + BIT_W'(1);
                end else begin
                    rx_cnt_r <= rx_cnt_r + CNT_W'(1);
                end
                if (rx_cnt_r == CNT_HALF) begin
                    if (rx_bit_r == BIT_W'(0)) begin
                        rx_busy_r <= ~rx_sync_r[1];
                    end else if (rx_bit_r == BIT_STOP) begin
                        rx_busy_r <= 1'b0;
                    end else begin
                        rx_shift_r <= {rx_sync_r[1], rx_shift_r[DATA_BITS-1:1]};
                    end
                end
            end
        end
    end

    // Ready flag: a completed byte sets it, ready_clr or clear drops it; set wins.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            ready_r    <= 1'b0;
            data_out_r <= '0;
        end else if (rx_stop_ok_s) begin
            ready_r    <= 1'b1;
            data_out_r <= rx_shift_r;
        end else if (ready_clr || clear) begin
            ready_r    <= 1'b0;
        end
    end

    // Transmit engine: start bit, LSB-first data, stop bit; busy drops at end of stop.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            tx_shift_r <= '1;
        end else if (!tx_busy_r) begin
            if (wr_en) begin
                tx_shift_r <= {1'b1, data_in};
                tx_r       <= 1'b0;
                tx_busy_r  <= 1'b1;
                tx_cnt_r   <= '0;
                tx_bit_r   <= '0;
            end
        end else if (tx_cnt_r != CNT_LAST) begin
            tx_cnt_r <= tx_cnt_r + CNT_W'(1);
        end else begin
            tx_cnt_r <= '0;
            if (tx_bit_r == BIT_STOP) begin
                tx_busy_r <= 1'b0;
            end else begin
                tx_r       <= tx_shift_r[0];
                tx_shift_r <= {1'b1, tx_shift_r[DATA_BITS:1]};
                tx_bit_r   <= tx_bit_r + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bus_bridge_initiator_uart_wrapper.sv
// Initiator-side bridge: decodes 4-byte UART request frames into a bus request
// and returns the 2-byte response frame over the same UART.
module bus_bridge_initiator_uart_wrapper
    import bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CLKS_PER_BIT   = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_rx,
    output logic             uart_tx,
    output logic             req_valid,
    input  logic             req_ready,
    output bus_bridge_req_t  req_payload,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  bus_bridge_resp_t resp_payload,
    output logic             frame_timeout,
    output logic [7:0]       rx_drop_cnt
);

    typedef enum logic [3:0] {
        RX_ADDR_L, RX_ADDR_H, RX_DATA, RX_FLAGS, REQ_ISSUE,
        WAIT_RESP, TX_DATA, TX_WAIT_DATA, TX_FLAGS, TX_WAIT_FLAGS
    } state_t;

    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state_r;
    logic [GAP_W-1:0] gap_r;
    logic             ready_q_r;
    logic             busy_q_r;
    logic             wr_en_r;
    logic [7:0]       data_in_r;
    bus_bridge_resp_t resp_q_r;
    bus_bridge_req_t  req_payload_r;
    logic             req_valid_r;
    logic             resp_ready_r;
    logic             frame_timeout_r;
    logic [7:0]       rx_drop_cnt_r;
    logic             uart_ready_s;
    logic [7:0]       uart_data_s;
    logic             tx_busy_s;
    logic             byte_det_s;
    logic             tx_done_s;
    logic             gap_hit_s;
    logic             gap_state_s;
    logic             rx_state_s;

    assign byte_det_s  = uart_ready_s && !ready_q_r;
    assign tx_done_s   = busy_q_r && !tx_busy_s;
    assign gap_hit_s   = (gap_r == GAP_W'(TIMEOUT_CYCLES - 1));
    assign gap_state_s = (state_r == RX_ADDR_H) || (state_r == RX_DATA) || (state_r == RX_FLAGS);
    assign rx_state_s  = gap_state_s || (state_r == RX_ADDR_L);

    assign req_valid     = req_valid_r;
    assign req_payload   = req_payload_r;
    assign resp_ready    = resp_ready_r;
    assign frame_timeout = frame_timeout_r;
    assign rx_drop_cnt   = rx_drop_cnt_r;

    ot_uart #(
        .DATA_BITS    (8),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk_50m   (clk),
        .rst_n     (rst_n),
        .data_in   (data_in_r),
        .wr_en     (wr_en_r),
        .clear     (1'b0),
        .ready_clr (byte_det_s),
        .Rx        (uart_rx),
        .Tx        (uart_tx),
        .Tx_busy   (tx_busy_s),
        .ready     (uart_ready_s),
        .data_out  (uart_data_s)
    );

    // Inter-byte gap counter: idle in RX_ADDR_L, restarted by every received byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_r <= '0;
        end else if (gap_state_s && !byte_det_s && !gap_hit_s) begin
            gap_r <= gap_r + GAP_W'(1);
        end else begin
            gap_r <= '0;
        end
    end

    // Bytes arriving while a transaction is in flight are dropped and counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_drop_cnt_r <= 8'h00;
        end else if (byte_det_s && !rx_state_s && (rx_drop_cnt_r != 8'hFF)) begin
            rx_drop_cnt_r <= rx_drop_cnt_r + 8'h01;
        end
    end

    // Frame sequencer; in RX states a byte arrival takes priority over timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= RX_ADDR_L;
            ready_q_r       <= 1'b0;
            busy_q_r        <= 1'b0;
            wr_en_r         <= 1'b0;
            data_in_r       <= 8'h00;
            resp_q_r        <= '0;
            req_payload_r   <= '0;
            req_valid_r     <= 1'b0;
            resp_ready_r    <= 1'b0;
            frame_timeout_r <= 1'b0;
        end else begin
            ready_q_r       <= uart_ready_s;
            busy_q_r        <= tx_busy_s;
            wr_en_r         <= 1'b0;
            frame_timeout_r <= 1'b0;
            case (state_r)
                RX_ADDR_L: begin
                    if (byte_det_s) begin
                        req_payload_r.addr[7:0] <= uart_data_s;
                        state_r                 <= RX_ADDR_H;
                    end
                end
                RX_ADDR_H: begin
                    if (byte_det_s) begin
                        req_payload_r.addr[15:8] <= uart_data_s;
                        state_r                  <= RX_DATA;
                    end else if (gap_hit_s) begin
                        frame_timeout_r <= 1'b1;
                        req_payload_r   <= '0;
                        state_r         <= RX_ADDR_L;
                    end
                end
                RX_DATA: begin
                    if (byte_det_s) begin
                        req_payload_r.write_data <= uart_data_s;
                        state_r                  <= RX_FLAGS;
                    end else if (gap_hit_s) begin
                        frame_timeout_r <= 1'b1;
                        req_payload_r   <= '0;
                        state_r         <= RX_ADDR_L;
                    end
                end
                RX_FLAGS: begin
                    if (byte_det_s) begin
                        req_payload_r.is_write <= uart_data_s[0];
                        req_valid_r            <= 1'b1;
                        state_r                <= REQ_ISSUE;
                    end else if (gap_hit_s) begin
                        frame_timeout_r <= 1'b1;
                        req_payload_r   <= '0;
                        state_r         <= RX_ADDR_L;
                    end
                end
                REQ_ISSUE: begin
                    if (req_ready) begin
                        req_valid_r  <= 1'b0;
                        resp_ready_r <= 1'b1;
                        state_r      <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (resp_valid) begin
                        resp_q_r     <= resp_payload;
                        resp_ready_r <= 1'b0;
                        state_r      <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (!tx_busy_s) begin
                        data_in_r <= resp_q_r.read_data;
                        wr_en_r   <= 1'b1;
                        state_r   <= TX_WAIT_DATA;
                    end
                end
                TX_WAIT_DATA: begin
                    if (tx_done_s) begin
                        state_r <= TX_FLAGS;
                    end
                end
                TX_FLAGS: begin
                    if (!tx_busy_s) begin
                        data_in_r <= resp_flags_byte(resp_q_r);
                        wr_en_r   <= 1'b1;
                        state_r   <= TX_WAIT_FLAGS;
                    end
                end
                TX_WAIT_FLAGS: begin
                    if (tx_done_s) begin
                        state_r <= RX_ADDR_L;
                    end
                end
                default: begin
                    state_r <= RX_ADDR_L;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_bridge_initiator_uart_wrapper.sv
// Directed plus randomized bench: serial frames in, bus handshakes and serial responses checked.
module tb_bus_bridge_initiator_uart_wrapper;
    import bus_bridge_pkg::*;

    localparam int CPB = 8;
    localparam int TMO = 200;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             uart_rx;
    logic             uart_tx;
    logic             req_valid;
    logic             req_ready;
    bus_bridge_req_t  req_payload;
    logic             resp_valid;
    logic             resp_ready;
    bus_bridge_resp_t resp_payload;
    logic             frame_timeout;
    logic [7:0]       rx_drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int hs_cnt       = 0;
    int tmo_cnt      = 0;
    int drops_sent   = 0;
    bus_bridge_req_t last_req;
    logic [7:0] txq[$];

    bus_bridge_initiator_uart_wrapper #(
        .TIMEOUT_CYCLES (TMO),
        .CLKS_PER_BIT   (CPB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_payload   (req_payload),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_payload  (resp_payload),
        .frame_timeout (frame_timeout),
        .rx_drop_cnt   (rx_drop_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1) begin
            hs_cnt   = hs_cnt + 1;
            last_req = req_payload;
        end
        if (rst_n === 1'b1 && frame_timeout === 1'b1) tmo_cnt = tmo_cnt + 1;
    end

    // Serial decoder for the response line.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            if (rst_n === 1'b1) begin
                repeat (CPB / 2) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(posedge clk);
                txq.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bus_bridge_req_t model_req(input logic [7:0] b0, b1, b2, b3);
        bus_bridge_req_t r;
        r.addr       = 16'(b1) * 16'd256 + 16'(b0);
        r.write_data = b2;
        r.is_write   = (b3 % 8'd2) == 8'd1;
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic expect_req(input string tag, input bus_bridge_req_t exp, input int hs_before);
        int n;
        n = 0;
        while (hs_cnt == hs_before && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_hs"}, 64'(hs_cnt - hs_before), 64'd1);
        check({tag, "_req"}, 64'(last_req), 64'(exp));
        @(negedge clk);
        check({tag, "_vld_drop"}, 64'(req_valid), 64'd0);
    endtask

    task automatic resp_handshake(input string tag, input bus_bridge_resp_t r);
        int n;
        n = 0;
        while (resp_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rrdy"}, 64'(resp_ready), 64'd1);
        resp_payload = r;
        resp_valid   = 1'b1;
        @(posedge clk);
        #1;
        resp_valid   = 1'b0;
        resp_payload = '0;
    endtask

    task automatic expect_tx(input string tag, input bus_bridge_resp_t r);
        int n;
        n = 0;
        while (txq.size() < 2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_txn"}, 64'(txq.size()), 64'd2);
        if (txq.size() >= 2) begin
            check({tag, "_tx0"}, 64'(txq.pop_front()), 64'(r.read_data));
            check({tag, "_tx1"}, 64'(txq.pop_front()), r.is_write ? 64'd1 : 64'd0);
        end
        txq.delete();
    endtask

    task automatic full_txn(input string tag, input logic [7:0] b0, b1, b2, b3, input bus_bridge_resp_t r);
        int hb;
        hb = hs_cnt;
        txq.delete();
        send_frame(b0, b1, b2, b3);
        expect_req(tag, model_req(b0, b1, b2, b3), hb);
        resp_handshake(tag, r);
        expect_tx(tag, r);
    endtask

    initial begin
        bus_bridge_req_t p0;
        bus_bridge_resp_t rr;
        int hb;
        int bad;
        int n;
        logic [7:0] rb[4];

        rst_n        = 1'b0;
        uart_rx      = 1'b1;
        req_ready    = 1'b1;
        resp_valid   = 1'b0;
        resp_payload = '0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_payload", 64'(req_payload), 64'd0);
        check("rst_resp_ready", 64'(resp_ready), 64'd0);
        check("rst_timeout", 64'(frame_timeout), 64'd0);
        check("rst_drop", 64'(rx_drop_cnt), 64'd0);
        check("rst_tx_idle", 64'(uart_tx), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        full_txn("read_a", 8'h34, 8'h12, 8'hA5, 8'h01, '{read_data: 8'h00, is_write: 1'b1});
        full_txn("read_b", 8'h10, 8'h40, 8'h00, 8'h00, '{read_data: 8'h5C, is_write: 1'b0});

        // Back-pressure: request must hold for 100 cycles and complete once.
        req_ready = 1'b0;
        hb = hs_cnt;
        txq.delete();
        send_frame(8'hEF, 8'hBE, 8'h3C, 8'hFE);
        n = 0;
        while (req_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("hold_vld", 64'(req_valid), 64'd1);
        p0 = req_payload;
        check("hold_payload", 64'(p0), 64'(model_req(8'hEF, 8'hBE, 8'h3C, 8'hFE)));
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_valid !== 1'b1 || req_payload !== p0) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        check("hold_no_hs", 64'(hs_cnt - hb), 64'd0);
        req_ready = 1'b1;
        expect_req("hold", p0, hb);
        repeat (20) @(negedge clk);
        check("hold_once", 64'(hs_cnt - hb), 64'd1);
        rr = '{read_data: 8'h99, is_write: 1'b0};
        resp_handshake("hold", rr);
        expect_tx("hold", rr);

        // Partial frame then silence.
        hb = hs_cnt;
        n  = tmo_cnt;
        send_byte(8'h34);
        send_byte(8'h12);
        repeat (TMO + 100) @(negedge clk);
        check("tmo_pulses", 64'(tmo_cnt - n), 64'd1);
        check("tmo_no_req", 64'(hs_cnt - hb), 64'd0);
        full_txn("after_tmo", 8'h00, 8'h80, 8'hFF, 8'h01, '{read_data: 8'h42, is_write: 1'b1});

        // Drops while waiting for the response.
        hb = hs_cnt;
        txq.delete();
        send_frame(8'h01, 8'h02, 8'h03, 8'h00);
        expect_req("drop1", model_req(8'h01, 8'h02, 8'h03, 8'h00), hb);
        send_byte(8'h77);
        drops_sent++;
        repeat (10) @(negedge clk);
        check("drop_cnt1", 64'(rx_drop_cnt), 64'(drops_sent));
        rr = '{read_data: 8'hC3, is_write: 1'b0};
        resp_handshake("drop1", rr);
        expect_tx("drop1", rr);

        hb = hs_cnt;
        send_frame(8'h55, 8'hAA, 8'h11, 8'h01);
        expect_req("drop2", model_req(8'h55, 8'hAA, 8'h11, 8'h01), hb);
        for (int i = 0; i < 299; i++) begin
            send_byte(8'($urandom));
            drops_sent++;
        end
        repeat (10) @(negedge clk);
        check("drop_sat", 64'(rx_drop_cnt), 64'((drops_sent > 255) ? 255 : drops_sent));
        rr = '{read_data: 8'h3E, is_write: 1'b1};
        resp_handshake("drop2", rr);
        expect_tx("drop2", rr);

        // Reset during the first response byte.
        hb = hs_cnt;
        send_frame(8'h21, 8'h43, 8'h65, 8'h00);
        expect_req("rst_mid", model_req(8'h21, 8'h43, 8'h65, 8'h00), hb);
        resp_handshake("rst_mid", '{read_data: 8'h0F, is_write: 1'b0});
        n = 0;
        while (uart_tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_txstart", 64'(uart_tx), 64'd0);
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_vld", 64'(req_valid), 64'd0);
        check("rst_mid_rrdy", 64'(resp_ready), 64'd0);
        check("rst_mid_payload", 64'(req_payload), 64'd0);
        check("rst_mid_drop", 64'(rx_drop_cnt), 64'd0);
        check("rst_mid_tmo", 64'(frame_timeout), 64'd0);
        check("rst_mid_tx", 64'(uart_tx), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (14 * CPB) @(negedge clk);
        txq.delete();
        full_txn("post_rst", 8'h78, 8'h56, 8'h9A, 8'h01, '{read_data: 8'hE7, is_write: 1'b1});

        // Randomized frames against the reference mapping.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) rb[j] = 8'($urandom);
            rr.read_data = 8'($urandom);
            rr.is_write  = 1'($urandom);
            full_txn($sformatf("rand%0d", k), rb[0], rb[1], rb[2], rb[3], rr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_bridge_initiator_uart_wrapper.md
BUS_BRIDGE_INITIATOR_UART_WRAPPER -- requirements
Module: bus_bridge_initiator_uart_wrapper

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000; maximum clk cycles allowed between two received bytes of one request frame.
REQ-002 clk  input  1  single clock, 50 MHz; drives ot_uart clk_50m.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 uart_rx  input  1  serial request frames from the remote target-side bridge.
REQ-005 uart_tx  output  1  serial response frames to the remote bridge.
REQ-006 req_valid  output  1  request payload valid toward the local bus initiator.
REQ-007 req_ready  input  1  local initiator accepts the request.
REQ-008 req_payload  output  bus_bridge_req_t  request fields {addr[15:0], write_data[7:0], is_write}.
REQ-009 resp_valid  input  1  response payload valid from the local initiator.
REQ-010 resp_ready  output  1  this block accepts the response.
REQ-011 resp_payload  input  bus_bridge_resp_t  response fields {read_data[7:0], is_write}.
REQ-012 frame_timeout  output  1  one-cycle pulse when a partial request frame is discarded.
REQ-013 rx_drop_cnt  output  8  saturating count of received bytes discarded outside the receive states.

Function
REQ-014 Byte reception is detected on the rising edge of the ot_uart ready output; ready_clr SHALL pulse for one cycle in the detection cycle.
REQ-015 Request frame byte order: byte0 addr[7:0], byte1 addr[15:8], byte2 write_data, byte3 flags (bit0 = is_write, bits 7:1 ignored).
REQ-016 The FSM states SHALL be RX_ADDR_L, RX_ADDR_H, RX_DATA, RX_FLAGS, REQ_ISSUE, WAIT_RESP, TX_DATA, TX_WAIT_DATA, TX_FLAGS, TX_WAIT_FLAGS; the reset state is RX_ADDR_L.
REQ-017 In each RX_* state, a detected byte SHALL be stored into its field and the FSM SHALL advance; RX_FLAGS advances to REQ_ISSUE.
REQ-018 REQ_ISSUE: req_valid=1 with a stable req_payload until the cycle req_valid&&req_ready, then the FSM SHALL go to WAIT_RESP; req_valid SHALL be 0 in the following cycle.
REQ-019 resp_ready SHALL be 1 only in WAIT_RESP; on resp_valid&&resp_ready, resp_payload is captured and the FSM goes to TX_DATA.
REQ-020 Response frame: byte0 read_data, byte1 {7'b0, is_write}; both bytes SHALL be sent for reads and for writes.
REQ-021 TX_DATA/TX_FLAGS: when Tx_busy=0, load data_in and pulse wr_en for one cycle, then go to the matching TX_WAIT_* state.
REQ-022 TX_WAIT_*: advance on tx_done, defined as registered Tx_busy=1 and current Tx_busy=0; TX_WAIT_FLAGS returns to RX_ADDR_L.
REQ-023 A gap counter SHALL run in RX_ADDR_H, RX_DATA and RX_FLAGS and clear on each detected byte; on reaching TIMEOUT_CYCLES it SHALL pulse frame_timeout, discard the partial frame and return to RX_ADDR_L. The counter SHALL be idle in RX_ADDR_L.
REQ-024 Bytes detected in REQ_ISSUE..TX_WAIT_FLAGS SHALL be cleared via ready_clr, discarded, and increment rx_drop_cnt, which saturates at 8'hFF.
REQ-025 If a timeout and a byte arrival occur in the same cycle, the byte SHALL win: it is stored and no timeout occurs.
REQ-026 Only one request is outstanding at a time; no request buffering.

Reset
REQ-027 During reset: state=RX_ADDR_L, req_valid=0, req_payload='0, resp_ready=0, frame_timeout=0, rx_drop_cnt=0, wr_en=0, ready_clr=0, gap counter=0, captured response='0.
REQ-028 Reset asserted mid-frame or mid-transmission SHALL abandon the transaction with no request issued; uart_tx idles high per ot_uart.

Structure
REQ-029 bus_bridge_req_t and bus_bridge_resp_t SHALL be taken from bus_bridge_pkg; the frame byte counts (4 and 2) SHALL be added to that package as constants.
REQ-030 The block SHALL contain exactly one sub-module, ot_uart (DATA_BITS=8, clear tied to 0); the FSM type is local to the module.

Verification
REQ-031 RX bytes 34,12,A5,01 -> req_payload {1234,A5,1}; resp {00,1} -> TX bytes 00,01.
REQ-032 RX bytes 10,40,00,00 -> req {4010,00,0}; resp {5C,0} -> TX bytes 5C,00.
REQ-033 req_ready held low for 100 cycles -> req_valid stays 1 with an unchanged payload; the handshake completes exactly once.
REQ-034 RX bytes 34,12, then idle > TIMEOUT_CYCLES -> one frame_timeout pulse; the next bytes 00,80,FF,01 -> req {8000,FF,1}.
REQ-035 Byte 77 received during WAIT_RESP -> rx_drop_cnt=1 and the response still transmitted correctly; 300 dropped bytes -> rx_drop_cnt=FF.
REQ-036 rst_n pulsed low during TX_WAIT_DATA -> all outputs at reset values and uart_tx high; the next full frame processes normally.
